load_store_unit: RTL and testbench

Multi-cycle load/store unit that sits between the RISC-V core's datapath and the data memory port. It is parametrised on memory bus width, and handles byte, halfword, word and (on a 64-bit bus) doubleword accesses, with signed or unsigned load extension. Unlike the fixed combinational byte-lane logic it replaces, it has a valid/ready request handshake, supports memories with wait states through an acknowledge, detects misaligned or illegal accesses, and applies a bus timeout.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/byte_lane_steer.sv | 69 ++++++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and size helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_D} size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // funct3[1:0] encodes log2 of the access size for every legal encoding
    function automatic size_t size_of(input logic [2:0] funct3);
        return size_t'(funct3[1:0]);
    endfunction

    function automatic int unsigned size_bytes(input logic [2:0] funct3);
        return 32'd1 << size_of(funct3);
    endfunction

endpackage

// File: rtl/byte_lane_steer.sv
// Combinational byte-lane logic: legality/alignment checks, store lane steering and
// load byte extraction with sign or zero extension.
module byte_lane_steer
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned LANES = DATA_W / 8,
    localparam int unsigned OFF_W = $clog2(LANES)
) (
    input  logic              write,
    input  logic [2:0]        funct3,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              legal,
    output logic              aligned,
    output logic [LANES-1:0]  byte_enable,
    output logic [DATA_W-1:0] wdata_steer,
    output logic [DATA_W-1:0] rdata_ext
);

    int unsigned       nbytes;
    logic [OFF_W-1:0]  mask;
    logic [DATA_W-1:0] wshift;
    logic [DATA_W-1:0] rshift;

    always_comb begin
        nbytes = size_bytes(funct3);
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_D:             legal = (DATA_W == 64);
            F3_BU, F3_HU:     legal = !write;
            F3_WU:            legal = !write && (DATA_W == 64);
            default:          legal = 1'b0;
        endcase
        // Doubleword mask truncates harmlessly on a 32-bit bus; such accesses are illegal anyway
        mask    = OFF_W'(nbytes - 1);
        aligned = ((offset & mask) == '0);
    end

    always_comb begin
        wshift = wdata << {offset, 3'b000};
        for (int k = 0; k < int'(LANES); k++) begin
            byte_enable[k] = (k >= int'(offset)) && (k < int'(offset) + int'(nbytes));
            wdata_steer[8*k +: 8] = byte_enable[k] ? wshift[8*k +: 8] : 8'h00;
        end
    end

    always_comb begin
        rshift = rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:  rdata_ext = {{(DATA_W-8){rshift[7]}}, rshift[7:0]};
            F3_BU: rdata_ext = {{(DATA_W-8){1'b0}}, rshift[7:0]};
            F3_H:  rdata_ext = {{(DATA_W-16){rshift[15]}}, rshift[15:0]};
            F3_HU: rdata_ext = {{(DATA_W-16){1'b0}}, rshift[15:0]};
            F3_W: begin
                // Fill with the sign, then restore the upper half of the word itself
                rdata_ext        = {{(DATA_W-16){rshift[31]}}, rshift[15:0]};
                rdata_ext[31:16] = rshift[31:16];
            end
            F3_WU: begin
                rdata_ext       = '0;
                rdata_ext[31:0] = rshift[31:0];
            end
            default: rdata_ext = rshift;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: request handshake, registered memory port with wait
// states, misalignment/legality faults and a bus timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_fault,
    output logic                mem_req,
    output logic                mem_memwrite,
    output logic [ADDR_W-1:0]   mem_adr,
    output logic [DATA_W/8-1:0] mem_byte_enable,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic                mem_ack
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t state_q, state_d;

    logic [2:0]        funct3_q;
    logic [OFF_W-1:0]  off_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              fault_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_adr_q;
    logic [LANES-1:0]  mem_be_q;
    logic [DATA_W-1:0] mem_wd_q;

    logic [2:0]        st_funct3;
    logic [OFF_W-1:0]  st_off;
    logic              legal;
    logic              aligned;
    logic [LANES-1:0]  byte_enable;
    logic [DATA_W-1:0] wdata_steer;
    logic [DATA_W-1:0] rdata_ext;
    logic              accept;
    logic              timeout_hit;

    // Live request drives the checks in IDLE; the latched request drives load extraction
    assign st_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
    assign st_off    = (state_q == IDLE) ? req_addr[OFF_W-1:0] : off_q;

    byte_lane_steer #(
        .DATA_W(DATA_W)
    ) u_steer (
        .write       (req_write),
        .funct3      (st_funct3),
        .offset      (st_off),
        .wdata       (req_wdata),
        .rdata       (mem_readdata),
        .legal       (legal),
        .aligned     (aligned),
        .byte_enable (byte_enable),
        .wdata_steer (wdata_steer),
        .rdata_ext   (rdata_ext)
    );

    assign accept      = (state_q == IDLE) && req_valid;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = (legal && aligned) ? ACCESS : RESP;
            ACCESS:  if (mem_ack || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_fault = rsp_valid && fault_q;
        rsp_rdata = rsp_valid ? rdata_q : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            funct3_q  <= '0;
            off_q     <= '0;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
            rdata_q   <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
            mem_be_q  <= '0;
            mem_wd_q  <= '0;
        end else begin
            mem_req_q <= (state_d == ACCESS);
            if (accept) begin
                funct3_q <= req_funct3;
                off_q    <= req_addr[OFF_W-1:0];
                fault_q  <= !(legal && aligned);
                rdata_q  <= '0;
                cnt_q    <= '0;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q + 1'b1;
                if (mem_ack) begin
                    rdata_q <= mem_we_q ? '0 : rdata_ext;
                end else if (timeout_hit) begin
                    fault_q <= 1'b1;
                end
            end
            if (state_d != ACCESS) begin
                mem_we_q  <= 1'b0;
                mem_adr_q <= '0;
                mem_be_q  <= '0;
                mem_wd_q  <= '0;
            end else if (accept) begin
                mem_we_q  <= req_write;
                mem_adr_q <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                mem_be_q  <= byte_enable;
                mem_wd_q  <= wdata_steer;
            end
        end
    end

    assign mem_req         = mem_req_q;
    assign mem_memwrite    = mem_we_q;
    assign mem_adr         = mem_adr_q;
    assign mem_byte_enable = mem_be_q;
    assign mem_writedata   = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit on a 32-bit bus (TIMEOUT=4) and a 64-bit bus.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        fault;
        logic [63:0] rdata;
        int          lat;
        int          mreq;
        logic        we;
        logic [31:0] adr;
        logic [7:0]  be;
        logic [63:0] wd;
    } exp_t;

    exp_t sb_q[$];

    logic        a_req_valid, a_req_ready, a_req_write;
    logic [2:0]  a_req_funct3;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_rsp_valid, a_rsp_fault;
    logic [31:0] a_rsp_rdata;
    logic        a_mem_req, a_mem_memwrite, a_mem_ack;
    logic [31:0] a_mem_adr, a_mem_wd, a_mem_rd;
    logic [3:0]  a_mem_be;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [2:0]  b_req_funct3;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata;
    logic        b_rsp_valid, b_rsp_fault;
    logic [63:0] b_rsp_rdata;
    logic        b_mem_req, b_mem_memwrite, b_mem_ack;
    logic [31:0] b_mem_adr;
    logic [63:0] b_mem_wd, b_mem_rd;
    logic [7:0]  b_mem_be;

    load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_fault(a_rsp_fault),
        .mem_req(a_mem_req), .mem_memwrite(a_mem_memwrite), .mem_adr(a_mem_adr),
        .mem_byte_enable(a_mem_be), .mem_writedata(a_mem_wd),
        .mem_readdata(a_mem_rd), .mem_ack(a_mem_ack)
    );

    load_store_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) u_dut64 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault),
        .mem_req(b_mem_req), .mem_memwrite(b_mem_memwrite), .mem_adr(b_mem_adr),
        .mem_byte_enable(b_mem_be), .mem_writedata(b_mem_wd),
        .mem_readdata(b_mem_rd), .mem_ack(b_mem_ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request, acks after `waits` ACCESS cycles and checks the response
    task automatic access(input bit is64, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [63:0] rd, input int waits,
                          input logic e_fault, input logic [63:0] e_rdata, input int e_lat,
                          input int e_mreq, input logic e_we, input logic [31:0] e_adr,
                          input logic [7:0] e_be, input logic [63:0] e_wd);
        exp_t e;
        exp_t got;
        int   cyc;
        int   nreq;
        bit   seen;
        e.fault = e_fault; e.rdata = e_rdata; e.lat = e_lat; e.mreq = e_mreq;
        e.we = e_we; e.adr = e_adr; e.be = e_be; e.wd = e_wd;
        sb_q.push_back(e);
        if (is64) begin
            b_req_valid = 1'b1; b_req_write = wr; b_req_funct3 = f3;
            b_req_addr = addr; b_req_wdata = wdata; b_mem_rd = rd;
        end else begin
            a_req_valid = 1'b1; a_req_write = wr; a_req_funct3 = f3;
            a_req_addr = addr; a_req_wdata = wdata[31:0]; a_mem_rd = rd[31:0];
        end
        chk("req_ready", is64 ? b_req_ready : a_req_ready, 1);
        @(negedge clk);
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        cyc  = 1;
        nreq = 0;
        seen = 0;
        while (!seen && cyc <= 40) begin
            if (is64 ? b_rsp_valid : a_rsp_valid) begin
                seen = 1;
            end else begin
                if (is64 ? b_mem_req : a_mem_req) begin
                    if (nreq == 0) begin
                        chk("mem_memwrite", is64 ? b_mem_memwrite : a_mem_memwrite, sb_q[0].we);
                        chk("mem_adr", is64 ? b_mem_adr : a_mem_adr, sb_q[0].adr);
                        chk("mem_be", is64 ? b_mem_be : a_mem_be, sb_q[0].be);
                        chk("mem_wd", is64 ? b_mem_wd : a_mem_wd, sb_q[0].wd);
                    end
                    nreq++;
                    if (is64) b_mem_ack = (nreq == waits + 1);
                    else      a_mem_ack = (nreq == waits + 1);
                end
                @(negedge clk);
                a_mem_ack = 1'b0;
                b_mem_ack = 1'b0;
                cyc++;
            end
        end
        got = sb_q.pop_front();
        chk("rsp_seen", 64'(seen), 1);
        if (seen) begin
            chk("rsp_fault", is64 ? b_rsp_fault : a_rsp_fault, got.fault);
            chk("rsp_rdata", is64 ? b_rsp_rdata : 64'(a_rsp_rdata), got.rdata);
            chk("latency", 64'(cyc), 64'(got.lat));
            chk("mem_req_cycles", 64'(nreq), 64'(got.mreq));
            chk("be_idle_in_resp", is64 ? b_mem_be : a_mem_be, 0);
            @(negedge clk);
            chk("rsp_one_cycle", is64 ? b_rsp_valid : a_rsp_valid, 0);
            chk("ready_after_resp", is64 ? b_req_ready : a_req_ready, 1);
        end
    endtask

    initial begin
        reset = 1'b1;
        a_req_valid = 0; a_req_write = 0; a_req_funct3 = 0; a_req_addr = 0; a_req_wdata = 0;
        a_mem_rd = 0; a_mem_ack = 0;
        b_req_valid = 0; b_req_write = 0; b_req_funct3 = 0; b_req_addr = 0; b_req_wdata = 0;
        b_mem_rd = 0; b_mem_ack = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", a_req_ready, 1);
        chk("rst_rsp_valid", a_rsp_valid, 0);
        chk("rst_rsp_fault", a_rsp_fault, 0);
        chk("rst_rsp_rdata", a_rsp_rdata, 0);
        chk("rst_mem_req", a_mem_req, 0);
        chk("rst_memwrite", a_mem_memwrite, 0);
        chk("rst_mem_adr", a_mem_adr, 0);
        chk("rst_mem_be", a_mem_be, 0);
        chk("rst_mem_wd", a_mem_wd, 0);
        chk("rst_ready64", b_req_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // 32-bit bus
        access(0, 1, 3'b000, 32'h103, 64'hAB, 0, 0,
               0, 0, 2, 1, 1, 32'h100, 8'h8, 64'hAB00_0000);
        access(0, 0, 3'b000, 32'h102, 0, 64'h0080_FF00, 3,
               0, 64'hFFFF_FF80, 5, 4, 0, 32'h100, 8'h4, 0);
        access(0, 0, 3'b100, 32'h102, 0, 64'h0080_FF00, 3,
               0, 64'h0000_0080, 5, 4, 0, 32'h100, 8'h4, 0);
        access(0, 0, 3'b001, 32'h101, 0, 0, 0,
               1, 0, 1, 0, 0, 0, 0, 0);
        access(0, 0, 3'b011, 32'h100, 0, 0, 0,
               1, 0, 1, 0, 0, 0, 0, 0);
        access(0, 0, 3'b010, 32'h200, 0, 64'h1234_5678, 100,
               1, 0, 5, 4, 0, 32'h200, 8'hF, 0);
        access(0, 1, 3'b001, 32'h102, 64'h1234_BEEF, 0, 1,
               0, 0, 3, 2, 1, 32'h100, 8'hC, 64'hBEEF_0000);
        access(0, 0, 3'b001, 32'h2, 0, 64'h8001_0000, 0,
               0, 64'hFFFF_8001, 2, 1, 0, 32'h0, 8'hC, 0);
        access(0, 0, 3'b101, 32'h2, 0, 64'h8001_0000, 0,
               0, 64'h0000_8001, 2, 1, 0, 32'h0, 8'hC, 0);
        access(0, 1, 3'b010, 32'h8, 64'hDEAD_BEEF, 0, 2,
               0, 0, 4, 3, 1, 32'h8, 8'hF, 64'hDEAD_BEEF);
        access(0, 1, 3'b100, 32'h8, 64'h55, 0, 0,
               1, 0, 1, 0, 0, 0, 0, 0);

        // Reset in the second ACCESS cycle abandons the access
        a_req_valid = 1; a_req_write = 0; a_req_funct3 = 3'b010; a_req_addr = 32'h40;
        @(negedge clk);
        a_req_valid = 0;
        @(negedge clk);
        chk("rst_mid_mem_req_before", a_mem_req, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_mem_req", a_mem_req, 0);
        chk("rst_mid_ready", a_req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid_no_rsp", a_rsp_valid, 0);
            @(negedge clk);
        end
        access(0, 0, 3'b010, 32'h10, 0, 64'hCAFE_F00D, 1,
               0, 64'hCAFE_F00D, 3, 2, 0, 32'h10, 8'hF, 0);

        // 64-bit bus
        access(1, 0, 3'b110, 32'h24, 0, 64'h89AB_CDEF_0123_4567, 0,
               0, 64'h0000_0000_89AB_CDEF, 2, 1, 0, 32'h20, 8'hF0, 0);
        access(1, 0, 3'b010, 32'h24, 0, 64'h89AB_CDEF_0123_4567, 0,
               0, 64'hFFFF_FFFF_89AB_CDEF, 2, 1, 0, 32'h20, 8'hF0, 0);
        access(1, 1, 3'b011, 32'h20, 64'h1122_3344_5566_7788, 0, 0,
               0, 0, 2, 1, 1, 32'h20, 8'hFF, 64'h1122_3344_5566_7788);
        access(1, 0, 3'b011, 32'h24, 0, 0, 0,
               1, 0, 1, 0, 0, 0, 0, 0);
        access(1, 1, 3'b000, 32'h25, 64'h5A, 0, 0,
               0, 0, 2, 1, 1, 32'h20, 8'h20, 64'h0000_5A00_0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
